// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-cell modulo counter: cell action encodings
// and default geometry.
package jk_mod_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_action_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_MOD   = 16;

endpackage

// File: rtl/jk_mod_counter_cell.sv
// One JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle; synchronous reset clears.
module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case (jk_action_e'({j, k}))
                JK_HOLD: q <= q;
                JK_CLR:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from JK cells; only J/K generation and the
// terminal-count flag live here, the state is held in the jk_cell instances.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MOD   = DEFAULT_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
        $error("jk_mod_counter: MOD out of range for WIDTH");
    end

    localparam bit               POW2 = (MOD == (2 ** WIDTH));
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] wrap_val;
    logic             out_of_range;
    logic             wrap;
    logic             up_chain;
    logic             dn_chain;

    // A plain +/-1 step is a T-style chain: a bit flips when every lower bit
    // is 1 (up) or 0 (down). Wraps for non-power-of-two moduli and recovery
    // from out-of-range states instead force each bit to the wrap value.
    always_comb begin
        toggle   = '0;
        up_chain = 1'b1;
        dn_chain = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = up ? up_chain : dn_chain;
            up_chain  = up_chain & q[i];
            dn_chain  = dn_chain & ~q[i];
        end

        out_of_range = ({1'b0, q} >= MODW);
        if (up) begin
            wrap     = ({1'b0, q} >= {1'b0, LAST});
            wrap_val = '0;
        end else begin
            wrap     = (q == '0) || out_of_range;
            wrap_val = (q == '0) ? LAST : '0;
        end

        j = '0;
        k = '0;
        if (load) begin
            j = din;
            k = ~din;
        end else if (en) begin
            if (wrap && !POW2) begin
                j = wrap_val;
                k = ~wrap_val;
            end else begin
                j = toggle;
                k = toggle;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    assign tc = en & ((up & (q == LAST)) | (~up & (q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: directed vectors push expected q/tc into a queue, a
// monitor pops and compares one entry per clock.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] q10;
    logic       tc10;
    logic [3:0] q16;
    logic       tc16;

    typedef struct {
        bit         sel16;
        logic [3:0] q;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
        .clk (clk), .rst (rst), .en (en), .up (up),
        .load(load), .din (din), .q (q10), .tc (tc10)
    );

    jk_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
        .clk (clk), .rst (rst), .en (en), .up (up),
        .load(load), .din (din), .q (q16), .tc (tc16)
    );

    task automatic apply_stimulus(input bit sel16, input logic r, input logic e,
                                  input logic u, input logic l, input logic [3:0] d,
                                  input logic [3:0] exp_q, input logic exp_tc,
                                  input string name);
        exp_t x;
        @(negedge clk);
        #1;
        rst  = r;
        en   = e;
        up   = u;
        load = l;
        din  = d;
        x.sel16 = sel16;
        x.q     = exp_q;
        x.tc    = exp_tc;
        x.name  = name;
        sb.push_back(x);
    endtask

    task automatic check_output(input exp_t x);
        logic [3:0] aq;
        logic       atc;
        aq  = x.sel16 ? q16 : q10;
        atc = x.sel16 ? tc16 : tc10;
        n_checks++;
        if (aq !== x.q || atc !== x.tc) begin
            n_fail++;
            $display("[TB] FAIL %s: got q=%0d tc=%b, expected q=%0d tc=%b",
                     x.name, aq, atc, x.q, x.tc);
        end
    endtask

    // Monitor: every edge the DUT presents a new state, compare it against the
    // oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) check_output(sb.pop_front());
        end
    end

    initial begin
        logic [3:0] up_seq [12];
        logic [3:0] ref16;
        up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

        apply_stimulus(0, 1, 0, 1, 0, 4'd0, 4'd0, 1'b0, "reset");
        foreach (up_seq[i])
            apply_stimulus(0, 0, 1, 1, 0, 4'd0, up_seq[i], up_seq[i] == 4'd9, "up_mod10");

        apply_stimulus(0, 1, 1, 0, 0, 4'd0, 4'd0, 1'b1, "reset_down_tc");
        apply_stimulus(0, 0, 1, 0, 0, 4'd0, 4'd9, 1'b0, "down_wrap");
        apply_stimulus(0, 0, 1, 0, 0, 4'd0, 4'd8, 1'b0, "down_8");
        apply_stimulus(0, 0, 1, 0, 0, 4'd0, 4'd7, 1'b0, "down_7");

        apply_stimulus(0, 0, 1, 1, 1, 4'd7, 4'd7, 1'b0, "load_wins");
        apply_stimulus(0, 0, 1, 1, 0, 4'd0, 4'd8, 1'b0, "after_load_8");
        apply_stimulus(0, 0, 1, 1, 0, 4'd0, 4'd9, 1'b1, "after_load_9");
        apply_stimulus(0, 0, 1, 1, 0, 4'd0, 4'd0, 1'b0, "after_load_wrap");

        apply_stimulus(0, 0, 1, 1, 1, 4'd13, 4'd13, 1'b0, "load_oor_up");
        apply_stimulus(0, 0, 1, 1, 0, 4'd0, 4'd0, 1'b0, "recover_up");
        apply_stimulus(0, 0, 1, 0, 1, 4'd13, 4'd13, 1'b0, "load_oor_down");
        apply_stimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 1'b1, "recover_down");

        apply_stimulus(0, 0, 0, 1, 1, 4'd5, 4'd5, 1'b0, "load_5");
        for (int i = 0; i < 5; i++)
            apply_stimulus(0, 0, 0, 1, 0, 4'd0, 4'd5, 1'b0, "hold_5");

        apply_stimulus(0, 1, 1, 1, 1, 4'd3, 4'd0, 1'b0, "rst_over_load");
        apply_stimulus(0, 0, 1, 1, 0, 4'd0, 4'd1, 1'b0, "dir_up_1");
        apply_stimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 1'b1, "dir_down_0");

        apply_stimulus(1, 1, 0, 1, 0, 4'd0, 4'd0, 1'b0, "reset16");
        ref16 = 4'd0;
        for (int i = 0; i < 17; i++) begin
            ref16 = ref16 + 4'd1;
            apply_stimulus(1, 0, 1, 1, 0, 4'd0, ref16, ref16 == 4'd15, "up_mod16");
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
